nes_joypad_port: RTL and testbench

- Responder for the 2A03 controller-port interface: decodes the CPU's $4016 write strobe and the $4016/$4017 read strobes.
- Implements two standard NES joypad shift registers (4021-style) plus the OUT[2:0] latch.
- Sits on the CPU data bus next to cpu_2a03; returns the serial button bit on D0 and open-bus filler on D7..D1.

---
 rtl/nes_joypad_port_if.sv | 28 ++
 rtl/nes_joypad_port.sv | 78 +++++++
 tb/tb_nes_joypad_port.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_joypad_port_if.sv
// CPU-side controller-port bus: $4016 write strobe with D2..D0, active-low $4016/$4017 read strobes, read data back.
// Strobes come straight from address decode; read data is combinational, with no handshake or backpressure.
interface nes_joypad_port_if;
  logic       addr4016w;
  logic [2:0] wdata;
  logic       naddr4016r;
  logic       naddr4017r;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output addr4016w,
    output wdata,
    output naddr4016r,
    output naddr4017r,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  addr4016w,
    input  wdata,
    input  naddr4016r,
    input  naddr4017r,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/nes_joypad_port.sv
// Two 4021-style NES pad shift registers plus the OUT[2:0] latch; read data is combinational and adds zero cycles.
// No backpressure: each read shifts exactly once, on the first clock after its strobe rises.
module nes_joypad_port #(
  parameter logic [7:0] OPEN_BUS = 8'h40,
  parameter logic       FILL_BIT = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  nes_joypad_port_if.slave   cpu,
  input  logic [7:0]         buttons_p1,
  input  logic [7:0]         buttons_p2,
  output logic [2:0]         out_latch,
  output logic [3:0]         shift_count_p1,
  output logic [3:0]         shift_count_p2
);

  logic [7:0] sr_p1;
  logic [7:0] sr_p2;
  logic       hist_4016;
  logic       hist_4017;
  logic       strobe;
  logic       shift_p1;
  logic       shift_p2;
  logic       serial_bit;

  assign strobe = out_latch[0];

  // A read ends when its strobe returns high; the strobe is judged on the latch value before any same-cycle write.
  assign shift_p1 = ~hist_4016 & cpu.naddr4016r & ~strobe;
  assign shift_p2 = ~hist_4017 & cpu.naddr4017r & ~strobe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_latch      <= 3'b000;
      sr_p1          <= 8'hFF;
      sr_p2          <= 8'hFF;
      shift_count_p1 <= 4'd0;
      shift_count_p2 <= 4'd0;
      hist_4016      <= 1'b1;
      hist_4017      <= 1'b1;
    end else begin
      hist_4016 <= cpu.naddr4016r;
      hist_4017 <= cpu.naddr4017r;
      if (cpu.addr4016w) begin
        out_latch <= cpu.wdata;
      end
      if (strobe) begin
        sr_p1          <= buttons_p1;
        sr_p2          <= buttons_p2;
        shift_count_p1 <= 4'd0;
        shift_count_p2 <= 4'd0;
      end else begin
        if (shift_p1) begin
          sr_p1          <= {FILL_BIT, sr_p1[7:1]};
          shift_count_p1 <= (shift_count_p1 == 4'd8) ? 4'd8 : shift_count_p1 + 4'd1;
        end
        if (shift_p2) begin
          sr_p2          <= {FILL_BIT, sr_p2[7:1]};
          shift_count_p2 <= (shift_count_p2 == 4'd8) ? 4'd8 : shift_count_p2 + 4'd1;
        end
      end
    end
  end

  // $4016 wins if both strobes are (illegally) low together.
  always_comb begin
    serial_bit = 1'b0;
    if (!cpu.naddr4016r) begin
      serial_bit = sr_p1[0];
    end else if (!cpu.naddr4017r) begin
      serial_bit = sr_p2[0];
    end
  end

  assign cpu.data_out = {OPEN_BUS[7:1], serial_bit};
  assign cpu.data_oe  = ~cpu.naddr4016r | ~cpu.naddr4017r;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: directed stimulus queues expected read bytes and state probes;
// a negedge monitor pops and compares them whenever the port drives the bus or a probe is posted.
module tb_nes_joypad_port;

  logic       clock;
  logic       reset;
  logic [7:0] buttons_p1;
  logic [7:0] buttons_p2;
  logic [2:0] out_latch;
  logic [3:0] shift_count_p1;
  logic [3:0] shift_count_p2;

  nes_joypad_port_if bus ();

  nes_joypad_port #(
    .OPEN_BUS(8'h40),
    .FILL_BIT(1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu           (bus),
    .buttons_p1    (buttons_p1),
    .buttons_p2    (buttons_p2),
    .out_latch     (out_latch),
    .shift_count_p1(shift_count_p1),
    .shift_count_p2(shift_count_p2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         sel;
    logic [7:0] exp;
  } probe_t;

  logic [7:0] rd_q[$];
  probe_t     st_q[$];
  string      nm_q[$];
  int         probe_req = 0;
  int         probe_ack = 0;
  bit         done = 0;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycles = 0;
  logic [7:0] exp_rd;
  logic [7:0] got;
  probe_t     pr;
  string      pnm;

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      0:       pick = bus.data_out;
      1:       pick = {7'd0, bus.data_oe};
      2:       pick = {5'd0, out_latch};
      3:       pick = {4'd0, shift_count_p1};
      default: pick = {4'd0, shift_count_p2};
    endcase
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clock) begin
    cycles++;
    if (!reset && bus.data_oe) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_unexpected: data_out=%h with no read expected", bus.data_out);
      end else begin
        exp_rd = rd_q.pop_front();
        if (bus.data_out !== exp_rd) begin
          n_bad++;
          $display("FAIL read_data: got %h expected %h", bus.data_out, exp_rd);
        end
      end
    end
    while (probe_ack < probe_req) begin
      pr  = st_q.pop_front();
      pnm = nm_q.pop_front();
      got = pick(pr.sel);
      n_cmp++;
      if (got !== pr.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", pnm, got, pr.exp);
      end
      probe_ack++;
    end
    if (done || cycles > 5000) begin
      if (!done) begin
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete within %0d cycles", cycles);
      end
      n_cmp++;
      if (rd_q.size() != 0) begin
        n_bad++;
        $display("FAIL reads_missing: got %0d reads left pending expected 0", rd_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic probe(input int sel, input logic [7:0] e, input string nm);
    st_q.push_back('{sel: sel, exp: e});
    nm_q.push_back(nm);
    probe_req++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] v);
    bus.addr4016w = 1'b1;
    bus.wdata     = v;
    tick();
    bus.addr4016w = 1'b0;
  endtask

  // n-cycle read of one port; the trailing tick is the shift edge.
  task automatic rd(input bit port, input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) rd_q.push_back(e);
    if (port) bus.naddr4017r = 1'b0;
    else      bus.naddr4016r = 1'b0;
    repeat (n) tick();
    bus.naddr4016r = 1'b1;
    bus.naddr4017r = 1'b1;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.addr4016w  = 1'b0;
    bus.wdata      = 3'b000;
    bus.naddr4016r = 1'b1;
    bus.naddr4017r = 1'b1;
    buttons_p1     = 8'h00;
    buttons_p2     = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset mid-operation
    wr(3'b110);
    rd(0, 1, 8'h41);
    probe(3, 8'd1, "cnt1_before_reset");
    probe(2, 8'd6, "latch_before_reset");
    rd_q.push_back(8'h41);
    bus.naddr4016r = 1'b0;
    tick();
    reset          = 1'b1;
    bus.naddr4016r = 1'b1;
    #2;
    reset = 1'b0;
    probe(2, 8'd0, "reset_out_latch");
    probe(1, 8'd0, "reset_data_oe");
    probe(0, 8'h40, "reset_data_out");
    probe(3, 8'd0, "reset_cnt1");
    tick();
    probe(3, 8'd0, "no_shift_after_reset");
    rd(0, 1, 8'h41);
    probe(3, 8'd1, "cnt1_first_read");

    // Eight reads of A,Start,Right, then exhaustion
    buttons_p1 = 8'b1000_1001;
    wr(3'b001);
    wr(3'b000);
    probe(3, 8'd0, "cnt1_after_latch");
    rd(0, 1, 8'h41); rd(0, 1, 8'h40); rd(0, 1, 8'h40); rd(0, 1, 8'h41);
    rd(0, 1, 8'h40); rd(0, 1, 8'h40); rd(0, 1, 8'h40); rd(0, 1, 8'h41);
    probe(3, 8'd8, "cnt1_after_8");
    rd(0, 1, 8'h41);
    rd(0, 1, 8'h41);
    probe(3, 8'd8, "cnt1_saturated");

    // Strobe held: live A bit, no shifting
    buttons_p1 = 8'h01;
    wr(3'b001);
    tick();
    rd(0, 1, 8'h41); rd(0, 1, 8'h41); rd(0, 1, 8'h41);
    probe(3, 8'd0, "cnt1_strobe_held");
    buttons_p1 = 8'h00;
    tick();
    rd(0, 1, 8'h40);
    wr(3'b000);

    // Three-cycle read, one shift
    buttons_p1 = 8'h02;
    wr(3'b001);
    wr(3'b000);
    rd(0, 3, 8'h40);
    probe(3, 8'd1, "cnt1_long_read");
    rd(0, 1, 8'h41);
    probe(3, 8'd2, "cnt1_after_b");

    // Pads independent
    buttons_p1 = 8'h01;
    buttons_p2 = 8'h02;
    wr(3'b001);
    wr(3'b000);
    rd(0, 1, 8'h41);
    rd(1, 1, 8'h40);
    rd(0, 1, 8'h40);
    rd(1, 1, 8'h41);
    probe(3, 8'd2, "cnt1_indep");
    probe(4, 8'd2, "cnt2_indep");

    // Latch write, then write coinciding with a read deassertion
    wr(3'b101);
    probe(2, 8'd5, "latch_101");
    wr(3'b000);
    probe(2, 8'd0, "latch_000");
    probe(3, 8'd0, "cnt1_relatched");
    rd_q.push_back(8'h41);
    bus.naddr4016r = 1'b0;
    tick();
    bus.naddr4016r = 1'b1;
    bus.addr4016w  = 1'b1;
    bus.wdata      = 3'b001;
    tick();
    bus.addr4016w = 1'b0;
    probe(3, 8'd1, "cnt1_shift_before_reload");
    probe(2, 8'd1, "latch_after_same_cycle");
    probe(1, 8'd0, "data_oe_idle");
    probe(0, 8'h40, "data_out_idle");
    tick();
    probe(3, 8'd0, "cnt1_after_reload");
    probe(4, 8'd0, "cnt2_after_reload");

    tick();
    done = 1'b1;
  end

endmodule
